drp_slave_regfile: RTL

- DRP responder: terminates a DRP master port (e.g. the one driven by the AXI-lite-to-DRP bridge) and backs it with a local register array.
- Used as a stand-in endpoint for bridge bring-up and as a configuration register bank in DRP-clocked fabric logic.
- Single clock domain. One DRP transaction is in flight at a time, with a fixed, parameterised EN-to-RDY latency.

---
 rtl/drp_slave_regfile.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/drp_slave_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : drp_slave_regfile                                             |
// | Brief    : DRP responder backed by a local register array with fixed     |
// |            EN-to-RDY latency; optional error counter via the macro       |
// |            DRP_SLAVE_ERR_CNT_EN (adds ERR_CNT / ERR_CNT_CLR ports).      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module drp_slave_regfile #(
    parameter int                          C_DRP_ADDR_WIDTH = 12,
    parameter int                          C_DRP_DATA_WIDTH = 16,
    parameter int                          C_REG_NUM        = 64,
    parameter int                          C_RDY_LATENCY    = 3,
    parameter logic [C_DRP_DATA_WIDTH-1:0] C_INIT_VALUE     = '0
) (
    input  logic                        S_DRPCLK,
    input  logic                        S_DRPRSTN,
    input  logic                        S_DRPEN,
    input  logic                        S_DRPWE,
    input  logic [C_DRP_ADDR_WIDTH-1:0] S_DRPADDR,
    input  logic [C_DRP_DATA_WIDTH-1:0] S_DRPDI,
    output logic [C_DRP_DATA_WIDTH-1:0] S_DRPDO,
    output logic                        S_DRPRDY,
    output logic                        S_BUSY,
    output logic                        S_ERR_PULSE,
`ifdef DRP_SLAVE_ERR_CNT_EN
    input  logic                        ERR_CNT_CLR,
    output logic [7:0]                  ERR_CNT,
`endif
    output logic                        USER_WR_PULSE,
    output logic [C_DRP_ADDR_WIDTH-1:0] USER_WR_ADDR,
    output logic [C_DRP_DATA_WIDTH-1:0] USER_WR_DATA
);

    localparam int                          IDX_W     = (C_REG_NUM > 1) ? $clog2(C_REG_NUM) : 1;
    localparam logic [C_DRP_ADDR_WIDTH:0]   REG_NUM_W = (C_DRP_ADDR_WIDTH + 1)'(C_REG_NUM);
    localparam logic [3:0]                  LAT_INIT  = 4'(C_RDY_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                        state_q;
    logic [3:0]                    cnt_q;
    logic                          we_q;
    logic [C_DRP_ADDR_WIDTH-1:0]   addr_q;
    logic [C_DRP_DATA_WIDTH-1:0]   di_q;
    logic [C_DRP_DATA_WIDTH-1:0]   regs_q [C_REG_NUM];

    logic [C_DRP_DATA_WIDTH-1:0]   do_q;
    logic                          rdy_q;
    logic                          busy_q;
    logic                          err_q;
    logic                          wr_pulse_q;
    logic [C_DRP_ADDR_WIDTH-1:0]   wr_addr_q;
    logic [C_DRP_DATA_WIDTH-1:0]   wr_data_q;

    logic                          accept;
    logic                          collision;
    logic                          enter_resp;
    logic                          resp_we;
    logic [C_DRP_ADDR_WIDTH-1:0]   resp_addr;
    logic [C_DRP_DATA_WIDTH-1:0]   resp_di;
    logic                          resp_in_range;
    logic [IDX_W-1:0]              resp_idx;
    logic [C_DRP_DATA_WIDTH-1:0]   rd_data;
    logic                          commit;

    // With latency 1 the response is formed straight from the bus inputs,
    // otherwise from the captured request.
    always_comb begin
        accept    = S_DRPEN && (state_q == ST_IDLE);
        collision = S_DRPEN && (state_q != ST_IDLE);
        if (state_q == ST_IDLE) begin
            enter_resp = accept && (C_RDY_LATENCY == 1);
            resp_we    = S_DRPWE;
            resp_addr  = S_DRPADDR;
            resp_di    = S_DRPDI;
        end else begin
            enter_resp = (state_q == ST_WAIT) && (cnt_q == 4'd1);
            resp_we    = we_q;
            resp_addr  = addr_q;
            resp_di    = di_q;
        end
        resp_in_range = ({1'b0, resp_addr} < REG_NUM_W);
        resp_idx      = resp_addr[IDX_W-1:0];
        rd_data       = resp_in_range ? regs_q[resp_idx] : '0;
        commit        = (state_q == ST_RESP) && we_q && resp_in_range;
    end

    always_ff @(posedge S_DRPCLK or negedge S_DRPRSTN) begin
        if (!S_DRPRSTN) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            di_q       <= '0;
            do_q       <= '0;
            rdy_q      <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            rdy_q      <= 1'b0;
            do_q       <= '0;
            wr_pulse_q <= 1'b0;
            err_q      <= collision;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        we_q    <= S_DRPWE;
                        addr_q  <= S_DRPADDR;
                        di_q    <= S_DRPDI;
                        cnt_q   <= LAT_INIT;
                        busy_q  <= 1'b1;
                        state_q <= (C_RDY_LATENCY == 1) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd1) begin
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
            if (enter_resp) begin
                rdy_q <= 1'b1;
                do_q  <= resp_we ? '0 : rd_data;
                if (!resp_in_range) begin
                    err_q <= 1'b1;
                end
                if (resp_we && resp_in_range) begin
                    wr_pulse_q <= 1'b1;
                    wr_addr_q  <= resp_addr;
                    wr_data_q  <= resp_di;
                end
            end
        end
    end

    // The array is written on the edge that closes the RESP cycle.
    always_ff @(posedge S_DRPCLK or negedge S_DRPRSTN) begin
        if (!S_DRPRSTN) begin
            for (int i = 0; i < C_REG_NUM; i++) begin
                regs_q[i] <= C_INIT_VALUE;
            end
        end else if (commit) begin
            regs_q[resp_idx] <= di_q;
        end
    end

`ifdef DRP_SLAVE_ERR_CNT_EN
    logic [7:0] err_cnt_q;
    logic [8:0] err_sum;

    always_comb begin
        err_sum = {1'b0, err_cnt_q} + {8'd0, collision}
                + {8'd0, enter_resp && !resp_in_range};
    end

    always_ff @(posedge S_DRPCLK or negedge S_DRPRSTN) begin
        if (!S_DRPRSTN) begin
            err_cnt_q <= '0;
        end else if (ERR_CNT_CLR) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end

    assign ERR_CNT = err_cnt_q;
`endif

    assign S_DRPDO       = do_q;
    assign S_DRPRDY      = rdy_q;
    assign S_BUSY        = busy_q;
    assign S_ERR_PULSE   = err_q;
    assign USER_WR_PULSE = wr_pulse_q;
    assign USER_WR_ADDR  = wr_addr_q;
    assign USER_WR_DATA  = wr_data_q;

endmodule
`default_nettype wire
